// File: rtl/prim_util_pkg_u.sv
// Shared width helpers for sizing counters and pointers.
// vbits(n) gives the bits needed to index n items, never less than one.
package prim_util_pkg_u;

    function automatic integer vbits(input integer value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding a UART shifter: registered head output,
// explicit pointer wrap for any depth, fill-level counter and low-watermark flag.
module uart_tx_fifo #(
    parameter  int unsigned Width  = 8,
    parameter  int unsigned Depth  = 32,
    localparam int unsigned PtrW   = prim_util_pkg_u::vbits(Depth),
    localparam int unsigned DepthW = prim_util_pkg_u::vbits(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o,
    output logic              full_o,
    input  logic [DepthW-1:0] wmark_i,
    output logic              wmark_o
);

    if (Depth < 2) begin : gen_depth_check
        $error("uart_tx_fifo: Depth must be at least 2");
    end

    localparam logic [PtrW-1:0]   PtrLast   = PtrW'(Depth - 1);
    localparam logic [DepthW-1:0] DepthFull = DepthW'(Depth);

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [DepthW-1:0] depth_q, depth_d;
    logic              wmark_q, wmark_d;
    logic              full;
    logic              wr_acc;
    logic              rd_acc;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full     = (depth_q == DepthFull);
    assign wready_o = !full;
    assign rvalid_o = (depth_q != '0);
    assign full_o   = full;
    assign depth_o  = depth_q;
    assign wmark_o  = wmark_q;
    assign rdata_o  = rvalid_o ? mem_q[rptr_q] : '0;

    // A flush swallows both handshakes of its cycle.
    assign wr_acc = wvalid_i && wready_o && !clr_i;
    assign rd_acc = rvalid_o && rready_i && !clr_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        depth_d = depth_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            depth_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (rd_acc) begin
                rptr_d = ptr_inc(rptr_q);
            end
            if (wr_acc && !rd_acc) begin
                depth_d = depth_q + DepthW'(1);
            end else if (rd_acc && !wr_acc) begin
                depth_d = depth_q - DepthW'(1);
            end
        end
        wmark_d = (wmark_i != '0) && (depth_d < wmark_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            depth_q <= '0;
            wmark_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            depth_q <= depth_d;
            wmark_q <= wmark_d;
        end
    end

    // Payload array carries no reset; the pointers and depth alone say what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a Depth=5 and a Depth=32 instance share one stimulus
// stream and are each compared every cycle against a queue-based model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wvalid;
    logic       rready;
    logic [7:0] wdata;
    logic [2:0] wm_a;
    logic [5:0] wm_b;
    int         wm;

    logic       wready_a, rvalid_a, full_a, wmark_a;
    logic [7:0] rdata_a;
    logic [2:0] depth_a;
    logic       wready_b, rvalid_b, full_b, wmark_b;
    logic [7:0] rdata_b;
    logic [5:0] depth_b;

    int tests  = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         exp_wm0, exp_wm1;

    always #5 clk = ~clk;

    uart_tx_fifo #(.Width(8), .Depth(5)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wready_a), .wdata_i(wdata),
        .rvalid_o(rvalid_a), .rready_i(rready), .rdata_o(rdata_a),
        .depth_o(depth_a), .full_o(full_a), .wmark_i(wm_a), .wmark_o(wmark_a)
    );

    uart_tx_fifo #(.Width(8), .Depth(32)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wready_b), .wdata_i(wdata),
        .rvalid_o(rvalid_b), .rready_i(rready), .rdata_o(rdata_b),
        .depth_o(depth_b), .full_o(full_b), .wmark_i(wm_b), .wmark_o(wmark_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_wm(input int v);
        wm   = v;
        wm_a = 3'(v);
        wm_b = 6'(v);
    endtask

    task automatic check_all();
        check_eq("a.depth",  32'(depth_a),  32'(q0.size()));
        check_eq("a.full",   32'(full_a),   32'(q0.size() == 5));
        check_eq("a.wready", 32'(wready_a), 32'(q0.size() != 5));
        check_eq("a.rvalid", 32'(rvalid_a), 32'(q0.size() != 0));
        check_eq("a.rdata",  32'(rdata_a),  (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
        check_eq("a.wmark",  32'(wmark_a),  32'(exp_wm0));
        check_eq("b.depth",  32'(depth_b),  32'(q1.size()));
        check_eq("b.full",   32'(full_b),   32'(q1.size() == 32));
        check_eq("b.wready", 32'(wready_b), 32'(q1.size() != 32));
        check_eq("b.rvalid", 32'(rvalid_b), 32'(q1.size() != 0));
        check_eq("b.rdata",  32'(rdata_b),  (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
        check_eq("b.wmark",  32'(wmark_b),  32'(exp_wm1));
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge,
    // compare at the next falling edge.
    task automatic step(input bit c, input bit wv, input bit rr, input logic [7:0] wd);
        bit wacc0, racc0, wacc1, racc1;
        clr    = c;
        wvalid = wv;
        rready = rr;
        wdata  = wd;
        #1;
        // Handshake outputs before the edge reflect only stored state (no fall-through).
        check_eq("a.rvalid_pre", 32'(rvalid_a), 32'(q0.size() != 0));
        check_eq("b.wready_pre", 32'(wready_b), 32'(q1.size() != 32));
        wacc0 = wv && !c && (q0.size() < 5);
        racc0 = rr && !c && (q0.size() > 0);
        wacc1 = wv && !c && (q1.size() < 32);
        racc1 = rr && !c && (q1.size() > 0);
        @(posedge clk);
        if (c) begin
            q0.delete();
            q1.delete();
        end else begin
            if (racc0) void'(q0.pop_front());
            if (wacc0) q0.push_back(wd);
            if (racc1) void'(q1.pop_front());
            if (wacc1) q1.push_back(wd);
        end
        exp_wm0 = (q0.size() < wm);
        exp_wm1 = (q1.size() < wm);
        @(negedge clk);
        check_all();
    endtask

    // Reset asserted between edges must take effect without waiting for a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        exp_wm0 = 1'b0;
        exp_wm1 = 1'b0;
        check_all();
        wvalid = 1'b1;
        rready = 1'b1;
        wdata  = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        wvalid = 1'b0;
        rready = 1'b0;
        wdata  = 8'h00;
        set_wm(0);
        exp_wm0 = 1'b0;
        exp_wm1 = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Three back-to-back writes, then drain in order.
        step(0, 1, 0, 8'h41);
        step(0, 1, 0, 8'h42);
        step(0, 1, 0, 8'h43);
        check_eq("seq.depth3", 32'(depth_a), 32'd3);
        step(0, 0, 1, 8'h00);
        check_eq("seq.rd2", 32'(rdata_a), 32'h42);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        check_eq("seq.empty", 32'(rvalid_a), 32'd0);

        // Fill the Depth=5 instance, hold the 6th, release with one read.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h10 + 8'(i));
        check_eq("full.flag", 32'(full_a), 32'd1);
        step(0, 1, 0, 8'h15);
        check_eq("full.held", 32'(depth_a), 32'd5);
        step(0, 1, 1, 8'h15);
        check_eq("full.rd", 32'(depth_a), 32'd4);
        step(0, 1, 0, 8'h15);
        check_eq("full.accept", 32'(full_a), 32'd1);

        // Clear with both handshakes requested: nothing consumed or stored.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h20 + 8'(i));
        check_eq("clr.pre", 32'(depth_b), 32'd10);
        step(1, 1, 1, 8'hAA);
        check_eq("clr.post", 32'(rvalid_b), 32'd0);

        // Continuous stream through several pointer wraps.
        step(0, 1, 0, 8'h80);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 8'h81 + 8'(i));
        check_eq("stream.depth", 32'(depth_a), 32'd1);

        // Watermark threshold 4.
        step(1, 0, 0, 8'h00);
        set_wm(4);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h30 + 8'(i));
        check_eq("wm.at4", 32'(wmark_a), 32'd0);
        step(0, 0, 1, 8'h00);
        check_eq("wm.at3", 32'(wmark_a), 32'd1);
        set_wm(0);
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        check_eq("wm.zero", 32'(wmark_b), 32'd0);

        // Async reset with the FIFO partly full, then an immediate first write.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h50 + 8'(i));
        async_reset();
        step(0, 1, 0, 8'h99);
        check_eq("rst.first_wr", 32'(rdata_a), 32'h99);

        // Randomised traffic with shifting read/write bias.
        for (int n = 0; n < 1500; n++) begin
            int  ph;
            bit  c, wv, rr;
            ph = (n / 250) % 3;
            if (n % 100 == 0) set_wm($urandom_range(0, 7));
            c  = ($urandom_range(0, 99) == 0);
            wv = (ph == 0) ? ($urandom_range(0, 9) < 8) : (ph == 1) ? ($urandom_range(0, 9) < 3)
                                                                      : ($urandom_range(0, 1) == 1);
            rr = (ph == 0) ? ($urandom_range(0, 9) < 3) : (ph == 1) ? ($urandom_range(0, 9) < 8)
                                                                      : ($urandom_range(0, 1) == 1);
            step(c, wv, rr, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
